// File: rtl/mat_mul_stream_if.sv
// Stream interface for mat_mul_stream: operand input beats, result output
// handshake and status flags.
interface mat_mul_stream_if #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 40
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] matrix;
  logic [1:0]        matrix_size;
  logic              signed_mode;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_value;
  logic              out_last;
  logic              busy;
  logic              err;

  modport slave (
    input  in_valid, matrix, matrix_size, signed_mode, out_ready,
    output in_ready, out_valid, out_value, out_last, busy, err
  );

  modport master (
    output in_valid, matrix, matrix_size, signed_mode, out_ready,
    input  in_ready, out_valid, out_value, out_last, busy, err
  );
endinterface

// File: rtl/mat_mul_stream.sv
// Streaming N x N matrix product C = W*X: loads W then X row-major, computes
// one multiply-accumulate per cycle and streams C out with valid/ready.
module mat_mul_stream #(
  parameter int DATA_W = 16,
  parameter int MAX_N  = 8,
  parameter int OUT_W  = 40
) (
  input  logic           clk,
  input  logic           rst,
  mat_mul_stream_if.slave bus
);

  localparam int          IW     = $clog2(MAX_N);
  localparam int          PW     = 2 * DATA_W;
  localparam int unsigned MAX_NU = MAX_N;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_W  = 3'd1;
  localparam logic [2:0] S_LOAD_X  = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_OUTPUT  = 3'd4;

  logic [2:0]        r_state;
  logic [DATA_W-1:0] r_w [MAX_N*MAX_N];
  logic [DATA_W-1:0] r_x [MAX_N*MAX_N];
  logic [IW-1:0]     r_nm1;
  logic [IW-1:0]     r_row;
  logic [IW-1:0]     r_col;
  logic [IW-1:0]     r_i;
  logic [IW-1:0]     r_j;
  logic [IW-1:0]     r_k;
  logic              r_signed;
  logic [OUT_W-1:0]  r_acc;
  logic [OUT_W-1:0]  r_out_value;
  logic              r_out_valid;
  logic              r_out_last;

  logic               w_in_ready;
  logic               w_accept;
  logic               w_col_end;
  logic               w_row_end;
  int unsigned        w_n;
  logic [IW-1:0]      w_nm1;
  logic [DATA_W-1:0]  w_a;
  logic [DATA_W-1:0]  w_b;
  logic signed [PW-1:0] w_prod_s;
  logic [PW-1:0]      w_prod_u;
  logic [OUT_W-1:0]   w_prod_ext;
  logic [OUT_W-1:0]   w_acc_next;

  // Beats are refused while reset is asserted so that reset dominates loading.
  assign w_in_ready = ((r_state == S_IDLE) || (r_state == S_LOAD_W) ||
                       (r_state == S_LOAD_X)) && !rst;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_col_end  = (r_col == r_nm1);
  assign w_row_end  = (r_row == r_nm1);

  always_comb begin
    w_n = MAX_NU;
    case (bus.matrix_size)
      2'd0:    w_n = 2;
      2'd1:    w_n = 4;
      2'd2:    w_n = 8;
      default: w_n = MAX_NU;
    endcase
    if (w_n > MAX_NU) w_n = MAX_NU;
  end
  assign w_nm1 = IW'(w_n - 1);

  assign w_a        = r_w[{r_i, r_k}];
  assign w_b        = r_x[{r_k, r_j}];
  assign w_prod_s   = $signed(w_a) * $signed(w_b);
  assign w_prod_u   = w_a * w_b;
  assign w_prod_ext = r_signed ? {{(OUT_W-PW){w_prod_s[PW-1]}}, w_prod_s}
                               : {{(OUT_W-PW){1'b0}}, w_prod_u};
  assign w_acc_next = r_acc + w_prod_ext;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      if (r_state == S_LOAD_X)      r_x[{r_row, r_col}] <= bus.matrix;
      else if (r_state == S_LOAD_W) r_w[{r_row, r_col}] <= bus.matrix;
      else                          r_w[0] <= bus.matrix;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_nm1       <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_signed    <= 1'b0;
      r_acc       <= '0;
      r_out_value <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_nm1    <= w_nm1;
            r_signed <= bus.signed_mode;
            r_row    <= '0;
            r_col    <= IW'(1);
            r_state  <= S_LOAD_W;
          end
        end
        S_LOAD_W, S_LOAD_X: begin
          if (w_accept) begin
            if (w_col_end) begin
              r_col <= '0;
              if (w_row_end) begin
                r_row <= '0;
                if (r_state == S_LOAD_W) begin
                  r_state <= S_LOAD_X;
                end else begin
                  r_i     <= '0;
                  r_j     <= '0;
                  r_k     <= '0;
                  r_acc   <= '0;
                  r_state <= S_COMPUTE;
                end
              end else begin
                r_row <= r_row + 1'b1;
              end
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          if (r_k == r_nm1) begin
            r_out_value <= w_acc_next;
            r_out_valid <= 1'b1;
            r_out_last  <= (r_i == r_nm1) && (r_j == r_nm1);
            r_acc       <= '0;
            r_k         <= '0;
            r_state     <= S_OUTPUT;
          end else begin
            r_acc <= w_acc_next;
            r_k   <= r_k + 1'b1;
          end
        end
        S_OUTPUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (r_out_last) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_COMPUTE;
              if (r_j == r_nm1) begin
                r_j <= '0;
                r_i <= r_i + 1'b1;
              end else begin
                r_j <= r_j + 1'b1;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.err       = bus.in_valid && !w_in_ready && !rst;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.out_value = r_out_value;
  assign bus.out_last  = r_out_last;

endmodule

// File: tb/tb_mat_mul_stream.sv
// Self-checking bench for mat_mul_stream: directed and random jobs compared
// against a plain-arithmetic matrix product model.
module tb_mat_mul_stream;
  localparam int DW = 16;
  localparam int MN = 8;
  localparam int OW = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mat_mul_stream_if #(.DATA_W(DW), .OUT_W(OW)) bus ();

  mat_mul_stream #(.DATA_W(DW), .MAX_N(MN), .OUT_W(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] wm [MN*MN];
  logic [DW-1:0] xm [MN*MN];
  int            n;
  logic          sg;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int code2n(input int code);
    case (code)
      0:       return 2;
      1:       return 4;
      2:       return 8;
      default: return MN;
    endcase
  endfunction

  function automatic logic [OW-1:0] ref_elem(input int i, input int j);
    logic [OW-1:0] acc;
    longint a, b, p;
    acc = '0;
    for (int k = 0; k < n; k++) begin
      a = sg ? longint'($signed(wm[i*MN+k])) : longint'(wm[i*MN+k]);
      b = sg ? longint'($signed(xm[k*MN+j])) : longint'(xm[k*MN+j]);
      p = a * b;
      acc = acc + p[OW-1:0];
    end
    return acc;
  endfunction

  function automatic logic [DW-1:0] stream_beat(input int idx);
    int e;
    if (idx < n*n) return wm[(idx/n)*MN + idx%n];
    e = idx - n*n;
    return xm[(e/n)*MN + e%n];
  endfunction

  // gap: 0 none, 1 every other cycle, 2 random. rmode: 0 ready=1, 1 random, 2 stall element 1 for 5 cycles.
  task automatic run_job(input int code, input logic sgm, input int gap, input int rmode, input bit errdrv);
    int idx, total, guard, t_last, t_ref, k, hold;
    bit v, rdy, waiting, prev_stall;
    logic [OW-1:0] prev_val;
    n = code2n(code);
    sg = sgm;
    total = 2*n*n;
    idx = 0; guard = 0; t_last = 0;
    while (idx < total && guard < 5000) begin
      @(negedge clk);
      guard++;
      case (gap)
        0:       v = 1'b1;
        1:       v = (guard % 2) == 1;
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.in_valid = v;
      bus.matrix   = stream_beat(idx);
      if (idx == 0) begin
        bus.matrix_size = 2'(code);
        bus.signed_mode = sgm;
      end else begin
        bus.matrix_size = 2'($urandom);
        bus.signed_mode = 1'($urandom);
      end
      bus.out_ready = 1'($urandom);
      #1;
      if (v) check("in_ready_load", bus.in_ready, 1);
      if (v && bus.in_ready) begin
        idx++;
        if (idx == total) t_last = cyc;
      end
    end
    check("load_done", idx, total);

    k = 0; guard = 0; hold = 0; t_ref = t_last; waiting = 1; prev_stall = 0; prev_val = '0;
    while (k < n*n && guard < 20000) begin
      @(negedge clk);
      guard++;
      v = errdrv ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.in_valid = v;
      bus.matrix   = DW'($urandom);
      #1;
      check("in_ready_busy", bus.in_ready, 0);
      check("err", bus.err, v);
      check("busy", bus.busy, 1);
      if (prev_stall) check("valid_held", bus.out_valid, 1);
      if (bus.out_valid) begin
        if (waiting) begin
          check("latency", cyc - t_ref, n + 1);
          waiting = 0;
        end
        if (prev_stall) check("value_held", bus.out_value, prev_val);
        case (rmode)
          0:       rdy = 1'b1;
          1:       rdy = 1'($urandom_range(0, 1));
          default: rdy = !(k == 1 && hold < 5);
        endcase
        if (!rdy) hold++;
        bus.out_ready = rdy;
        if (rdy) begin
          check("value", bus.out_value, ref_elem(k / n, k % n));
          check("last", bus.out_last, (k == n*n-1));
          k++;
          t_ref = cyc;
          waiting = 1;
          prev_stall = 0;
        end else begin
          prev_stall = 1;
          prev_val = bus.out_value;
        end
      end else begin
        check("last_no_valid", bus.out_last, 0);
        bus.out_ready = 1'($urandom);
      end
    end
    check("out_done", k, n*n);
    if (rmode == 2) check("stall_cycles", hold, 5);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("idle_busy", bus.busy, 0);
    check("idle_in_ready", bus.in_ready, 1);
    check("idle_valid", bus.out_valid, 0);
  endtask

  task automatic set_2x2();
    wm[0] = 1; wm[1] = 2; wm[MN] = 3; wm[MN+1] = 4;
    xm[0] = 5; xm[1] = 6; xm[MN] = 7; xm[MN+1] = 8;
  endtask

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.matrix = '0;
    bus.matrix_size = '0;
    bus.signed_mode = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b1;
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_err", bus.err, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_value", bus.out_value, 0);
    check("rst_last", bus.out_last, 0);
    check("post_rst_in_ready", bus.in_ready, 1);

    set_2x2();
    run_job(0, 1'b0, 0, 0, 1'b0);

    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        wm[i*MN+k] = DW'(i*4 + k + 1);
        xm[i*MN+k] = DW'(i*4 + k + 1);
      end
    run_job(1, 1'b0, 0, 1, 1'b0);

    wm[0] = 16'hFFFF; wm[1] = 2; wm[MN] = 3; wm[MN+1] = 16'hFFFC;
    xm[0] = 1; xm[1] = 0; xm[MN] = 0; xm[MN+1] = 1;
    run_job(0, 1'b1, 0, 0, 1'b0);
    run_job(0, 1'b0, 0, 0, 1'b0);

    for (int i = 0; i < MN*MN; i++) begin
      wm[i] = 16'hFFFF;
      xm[i] = 16'hFFFF;
    end
    run_job(2, 1'b0, 0, 0, 1'b0);
    run_job(3, 1'b0, 1, 0, 1'b0);

    set_2x2();
    run_job(0, 1'b0, 0, 2, 1'b1);

    // Abort a 4x4 load after three W beats, then run a clean 2x2 job.
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.matrix = DW'(b + 1);
      bus.matrix_size = 2'd1;
      bus.signed_mode = 1'b0;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_valid", bus.out_valid, 0);
    check("abort_value", bus.out_value, 0);
    check("abort_in_ready", bus.in_ready, 1);
    set_2x2();
    run_job(0, 1'b0, 0, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < MN*MN; i++) begin
        wm[i] = DW'($urandom);
        xm[i] = DW'($urandom);
      end
      run_job(int'($urandom_range(0, 3)), 1'($urandom), 2, 1, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
